gcd_host_ctrl: RTL

- Initiator-side sequencer for the team's GCD core; drives that core's Start/Ack handshake.
- Queues operand pairs from upstream (switch/button loader or test source) in a small FIFO and launches each pair into the core.
- Captures AB_GCD when the core reaches Done, then acknowledges so the core returns to its initial state.
- Presents each result downstream with valid/ready, plus latency, zero-operand and timeout flags.

---
 rtl/gcd_host_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gcd_host_ctrl.sv
// Initiator-side sequencer for the GCD core: queues operand pairs, runs the
// Start/Ack handshake, and presents each result downstream with status flags.
module gcd_host_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CW      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_a,
  output logic [7:0]    res_b,
  output logic [7:0]    res_gcd,
  output logic [CW-1:0] res_cycles,
  output logic          res_zero,
  output logic          res_timeout,
  output logic [7:0]    pairs_done,
  input  logic          step_mode,
  input  logic          step_pulse,
  output logic [7:0]    Ain,
  output logic [7:0]    Bin,
  output logic          Start,
  output logic          Ack,
  output logic          SCEN,
  output logic          CoreRst,
  input  logic          q_I,
  input  logic          q_Done,
  input  logic [7:0]    AB_GCD
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ZERO    = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    ACK     = 3'd4,
    RECOVER = 3'd5,
    OUT     = 3'd6
  } state_t;

  state_t        state;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [CW-1:0] cyc_cnt;
  logic          push;
  logic          pop;

  assign in_ready = (count != PW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0) && !res_valid;

  assign SCEN    = step_mode ? step_pulse : 1'b1;
  assign Start   = (state == START);
  assign Ack     = (state == ACK);
  assign CoreRst = (state == RECOVER);

  // Operand storage; contents need no reset since count gates every read.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: launch, monitor, capture, and hand off one pair at a time.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      Ain         <= '0;
      Bin         <= '0;
      cyc_cnt     <= '0;
      res_valid   <= 1'b0;
      res_zero    <= 1'b0;
      res_timeout <= 1'b0;
      res_a       <= '0;
      res_b       <= '0;
      res_gcd     <= '0;
      res_cycles  <= '0;
      pairs_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_a  <= mem_a[rd_ptr];
            op_b  <= mem_b[rd_ptr];
            Ain   <= mem_a[rd_ptr];
            Bin   <= mem_b[rd_ptr];
            state <= ((mem_a[rd_ptr] == '0) || (mem_b[rd_ptr] == '0)) ? ZERO : START;
          end
        end
        ZERO: begin
          res_gcd    <= op_a | op_b;
          res_zero   <= 1'b1;
          res_cycles <= '0;
          res_a      <= op_a;
          res_b      <= op_b;
          res_valid  <= 1'b1;
          state      <= OUT;
        end
        START: begin
          cyc_cnt <= '0;
          if (q_I) state <= RUN;
        end
        RUN: begin
          if (q_Done) begin
            res_gcd    <= AB_GCD;
            res_cycles <= cyc_cnt;
            state      <= ACK;
          end else if (cyc_cnt == CW'(TIMEOUT)) begin
            state <= RECOVER;
          end else if (SCEN && (cyc_cnt != '1)) begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        ACK: begin
          res_a     <= op_a;
          res_b     <= op_b;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        RECOVER: begin
          res_gcd     <= '0;
          res_timeout <= 1'b1;
          res_cycles  <= CW'(TIMEOUT);
          res_a       <= op_a;
          res_b       <= op_b;
          res_valid   <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            res_zero    <= 1'b0;
            res_timeout <= 1'b0;
            pairs_done  <= pairs_done + 8'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
